// File: rtl/frame_capture_sequencer.sv
// -----------------------------------------------------------------------------
// frame_capture_sequencer
//
// Purpose:
//   Sits between NUM_CAMS free-running camera pipelines and the stereo/SSD
//   engine. Each camera's BRAM write strobe is gated so that only whole frames
//   are stored: the first accepted write is word 0 and the last is word
//   FRAME_WORDS-1. When every channel holds a complete frame, the engine is
//   started with a one-cycle pulse. The sequencer then waits for the engine's
//   done pulse, publishes the result and either re-arms (continuous pacing)
//   or returns to IDLE (single shot).
//
// Optional feature:
//   FRAME_SEQ_TIMEOUT_EN - builds a collection watchdog. If COLLECT lasts
//   TIMEOUT_CYCLES cycles without a channel starting a frame, timeout_out
//   becomes sticky-high and all partial frames are discarded. When the macro
//   is undefined no counter exists and timeout_out is tied low.
//
// Ports:
//   clk_in          system clock, rising edge
//   rst_n_in        asynchronous active-low reset
//   pacing_in       run enable
//   single_shot_in  1 = one capture/process pass, then IDLE
//   cam_addr_in     per-camera write address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   cam_wea_in      per-camera raw write strobe
//   cam_wea_out     gated write strobe to the frame BRAMs
//   cam_done_out    per-channel frame-complete flags
//   collecting_out  high while in COLLECT
//   new_frame_out   one-cycle engine start pulse
//   frame_done_in   engine done pulse (only honoured in PROCESS)
//   get_output_out  result valid, held until the next new_frame_out
//   frame_count_out completed processing passes (wraps)
//   state_out       IDLE=0, COLLECT=1, PROCESS=2, DONE=3
//   timeout_out     sticky watchdog flag
// -----------------------------------------------------------------------------
module frame_capture_sequencer #(
    parameter int NUM_CAMS       = 2,
    parameter int ADDR_WIDTH     = 17,
    parameter int FRAME_WORDS    = 12800,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           pacing_in,
    input  logic                           single_shot_in,
    input  logic [NUM_CAMS*ADDR_WIDTH-1:0] cam_addr_in,
    input  logic [NUM_CAMS-1:0]            cam_wea_in,
    output logic [NUM_CAMS-1:0]            cam_wea_out,
    output logic [NUM_CAMS-1:0]            cam_done_out,
    output logic                           collecting_out,
    output logic                           new_frame_out,
    input  logic                           frame_done_in,
    output logic                           get_output_out,
    output logic [COUNT_WIDTH-1:0]         frame_count_out,
    output logic [1:0]                     state_out,
    output logic                           timeout_out
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PROCESS = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_CAMS-1:0]     started_q, started_d;
    logic [NUM_CAMS-1:0]     finished_q, finished_d;
    logic                    new_frame_q, new_frame_d;
    logic                    get_output_q, get_output_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;

    logic [NUM_CAMS-1:0]     addr_zero_s;
    logic [NUM_CAMS-1:0]     addr_end_s;
    logic                    collecting_s;
    logic                    all_finished_s;
    logic                    wd_expire_s;

    // Per-channel address decode; comparisons are unsigned at ADDR_WIDTH.
    for (genvar g = 0; g < NUM_CAMS; g++) begin : g_chan
        assign addr_zero_s[g] = (cam_addr_in[g*ADDR_WIDTH +: ADDR_WIDTH] == {ADDR_WIDTH{1'b0}});
        assign addr_end_s[g]  = (cam_addr_in[g*ADDR_WIDTH +: ADDR_WIDTH] >= LAST_ADDR);
    end

    assign collecting_s   = (state_q == ST_COLLECT);
    assign all_finished_s = &finished_q;

    // The word-0 write passes before started is registered (addr_zero term);
    // everything after the frame's last word is blocked by finished.
    assign cam_wea_out = cam_wea_in & {NUM_CAMS{collecting_s}}
                       & (started_q | addr_zero_s) & ~finished_q;

    assign cam_done_out    = finished_q;
    assign collecting_out  = collecting_s;
    assign new_frame_out   = new_frame_q;
    assign get_output_out  = get_output_q;
    assign frame_count_out = count_q;
    assign state_out       = state_q;

    // Next-state, per-channel frame tracking and result bookkeeping.
    always_comb begin
        state_d      = state_q;
        started_d    = started_q;
        finished_d   = finished_q;
        new_frame_d  = 1'b0;
        get_output_d = get_output_q;
        count_d      = count_q;
        case (state_q)
            ST_IDLE: begin
                started_d  = {NUM_CAMS{1'b0}};
                finished_d = {NUM_CAMS{1'b0}};
                if (pacing_in) begin
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                // Abort wins over completion: pacing is the run enable.
                if (!pacing_in) begin
                    state_d    = ST_IDLE;
                    started_d  = {NUM_CAMS{1'b0}};
                    finished_d = {NUM_CAMS{1'b0}};
                end else if (all_finished_s) begin
                    state_d      = ST_PROCESS;
                    new_frame_d  = 1'b1;
                    get_output_d = 1'b0;
                    started_d    = {NUM_CAMS{1'b0}};
                    finished_d   = {NUM_CAMS{1'b0}};
                end else if (wd_expire_s) begin
                    started_d  = {NUM_CAMS{1'b0}};
                    finished_d = {NUM_CAMS{1'b0}};
                end else begin
                    // A repeated word 0 before finish just restarts the frame.
                    started_d  = started_q | (cam_wea_in & addr_zero_s);
                    finished_d = finished_q | (started_q & cam_wea_in & addr_end_s);
                end
            end
            ST_PROCESS: begin
                if (frame_done_in) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PROCESS;
                end
            end
            ST_DONE: begin
                get_output_d = 1'b1;
                count_d      = count_q + COUNT_WIDTH'(1);
                if (pacing_in && !single_shot_in) begin
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                started_d  = {NUM_CAMS{1'b0}};
                finished_d = {NUM_CAMS{1'b0}};
            end
        endcase
    end

    // Sequencer state and result registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            started_q    <= {NUM_CAMS{1'b0}};
            finished_q   <= {NUM_CAMS{1'b0}};
            new_frame_q  <= 1'b0;
            get_output_q <= 1'b0;
            count_q      <= {COUNT_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            started_q    <= started_d;
            finished_q   <= finished_d;
            new_frame_q  <= new_frame_d;
            get_output_q <= get_output_d;
            count_q      <= count_d;
        end
    end

`ifdef FRAME_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    // Expiry is the cycle in which the counter would reach TIMEOUT_CYCLES.
    assign wd_expire_s = collecting_s && (wd_q == WD_LAST);
    assign timeout_out = timeout_q;

    // Watchdog: idle at zero outside COLLECT, restarted whenever a channel starts.
    always_comb begin
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (!collecting_s) begin
            wd_d = {WD_W{1'b0}};
        end else if (wd_expire_s) begin
            wd_d      = {WD_W{1'b0}};
            timeout_d = 1'b1;
        end else if (|(started_d & ~started_q)) begin
            wd_d = {WD_W{1'b0}};
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    // Watchdog registers; the timeout flag only clears on reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wd_q      <= {WD_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign wd_expire_s = 1'b0;
    assign timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_frame_capture_sequencer.sv
module tb_frame_capture_sequencer;

    localparam int NC  = 2;
    localparam int AW  = 17;
    localparam int FW  = 16;
    localparam int TO  = 50;
    localparam int CW  = 2;

    logic             clk_in = 1'b0;
    logic             rst_n_in = 1'b0;
    logic             pacing_in = 1'b0;
    logic             single_shot_in = 1'b0;
    logic [NC*AW-1:0] cam_addr_in = '0;
    logic [NC-1:0]    cam_wea_in = '0;
    logic [NC-1:0]    cam_wea_out;
    logic [NC-1:0]    cam_done_out;
    logic             collecting_out;
    logic             new_frame_out;
    logic             frame_done_in = 1'b0;
    logic             get_output_out;
    logic [CW-1:0]    frame_count_out;
    logic [1:0]       state_out;
    logic             timeout_out;

    int checks = 0;
    int failures = 0;

    frame_capture_sequencer #(
        .NUM_CAMS(NC), .ADDR_WIDTH(AW), .FRAME_WORDS(FW),
        .TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CW)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .pacing_in(pacing_in),
        .single_shot_in(single_shot_in), .cam_addr_in(cam_addr_in),
        .cam_wea_in(cam_wea_in), .cam_wea_out(cam_wea_out),
        .cam_done_out(cam_done_out), .collecting_out(collecting_out),
        .new_frame_out(new_frame_out), .frame_done_in(frame_done_in),
        .get_output_out(get_output_out), .frame_count_out(frame_count_out),
        .state_out(state_out), .timeout_out(timeout_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input int a0, input bit w0, input int a1, input bit w1);
        cam_addr_in[0*AW +: AW] = AW'(a0);
        cam_addr_in[1*AW +: AW] = AW'(a1);
        cam_wea_in = {w1, w0};
        #1;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        pacing_in = 1'b1;
        drive(0, 1'b1, 0, 1'b1);
        checks++;
        if ({state_out, cam_done_out, collecting_out, new_frame_out, get_output_out,
             frame_count_out, timeout_out, cam_wea_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: state=%0d done=%b coll=%b nf=%b go=%b cnt=%0d to=%b wea=%b required all 0",
                     state_out, cam_done_out, collecting_out, new_frame_out, get_output_out,
                     frame_count_out, timeout_out, cam_wea_out);
        end
        pacing_in = 1'b0;
        drive(0, 1'b0, 0, 1'b0);
        cyc();
        rst_n_in = 1'b1;
        cyc();
        checks++;
        if (state_out !== 2'd0) begin
            failures++;
            $display("FAIL reset_idle: state=%0d required 0", state_out);
        end
    endtask

    task automatic test_full_frame();
        int bad = 0;
        pacing_in = 1'b1;
        cyc();
        checks++;
        if (state_out !== 2'd1 || collecting_out !== 1'b1) begin
            failures++;
            $display("FAIL enter_collect: state=%0d coll=%b required 1/1", state_out, collecting_out);
        end
        for (int k = 0; k < FW; k++) begin
            drive(k, 1'b1, k, 1'b1);
            if (cam_wea_out !== 2'b11) bad++;
            cyc();
        end
        drive(0, 1'b0, 0, 1'b0);
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL full_wea_pass: %0d gated cycles required 0", bad);
        end
        checks++;
        if (cam_done_out !== 2'b11 || new_frame_out !== 1'b0 || state_out !== 2'd1) begin
            failures++;
            $display("FAIL full_flags: done=%b nf=%b state=%0d required 11/0/1",
                     cam_done_out, new_frame_out, state_out);
        end
        cyc();
        checks++;
        if (new_frame_out !== 1'b1 || state_out !== 2'd2 || cam_done_out !== 2'b00) begin
            failures++;
            $display("FAIL full_pulse: nf=%b state=%0d done=%b required 1/2/00",
                     new_frame_out, state_out, cam_done_out);
        end
        cyc();
        checks++;
        if (new_frame_out !== 1'b0 || state_out !== 2'd2) begin
            failures++;
            $display("FAIL full_pulse_width: nf=%b state=%0d required 0/2", new_frame_out, state_out);
        end
    endtask

    task automatic test_process_done(input logic [CW-1:0] exp_cnt, input logic [1:0] exp_next);
        frame_done_in = 1'b1;
        cyc();
        frame_done_in = 1'b0;
        checks++;
        if (state_out !== 2'd3 || get_output_out !== 1'b0) begin
            failures++;
            $display("FAIL done_state: state=%0d go=%b required 3/0", state_out, get_output_out);
        end
        cyc();
        checks++;
        if (get_output_out !== 1'b1 || frame_count_out !== exp_cnt || state_out !== exp_next) begin
            failures++;
            $display("FAIL done_result: go=%b cnt=%0d state=%0d required 1/%0d/%0d",
                     get_output_out, frame_count_out, state_out, exp_cnt, exp_next);
        end
    endtask

    task automatic test_late_entry();
        int bad = 0;
        int hold_bad = 0;
        bit e0, e1;
        for (int j = 0; j < 25; j++) begin
            drive((7 + j) % FW, 1'b1, j % FW, 1'b1);
            e0 = (j >= 9);
            e1 = (j < 16);
            if (cam_wea_out !== {e1, e0}) bad++;
            if (get_output_out !== 1'b1) hold_bad++;
            cyc();
            if (j == 15) begin
                checks++;
                if (cam_done_out !== 2'b10) begin
                    failures++;
                    $display("FAIL late_cam1_done: done=%b required 10", cam_done_out);
                end
            end
        end
        drive(0, 1'b0, 0, 1'b0);
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL late_gating: %0d wrong strobe cycles required 0", bad);
        end
        checks++;
        if (hold_bad != 0) begin
            failures++;
            $display("FAIL get_output_hold: %0d cycles low required 0", hold_bad);
        end
        checks++;
        if (cam_done_out !== 2'b11 || new_frame_out !== 1'b0) begin
            failures++;
            $display("FAIL late_done: done=%b nf=%b required 11/0", cam_done_out, new_frame_out);
        end
        cyc();
        checks++;
        if (new_frame_out !== 1'b1 || get_output_out !== 1'b0 || state_out !== 2'd2) begin
            failures++;
            $display("FAIL late_pulse: nf=%b go=%b state=%0d required 1/0/2",
                     new_frame_out, get_output_out, state_out);
        end
    endtask

    task automatic test_single_shot();
        int pulses = 0;
        single_shot_in = 1'b1;
        test_process_done(2'd2, 2'd0);
        single_shot_in = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            frame_done_in = (c == 100);
            if (new_frame_out === 1'b1) pulses++;
            cyc();
        end
        frame_done_in = 1'b0;
        checks++;
        if (pulses != 0 || frame_count_out !== 2'd2 || state_out !== 2'd1) begin
            failures++;
            $display("FAIL single_shot_quiet: pulses=%0d cnt=%0d state=%0d required 0/2/1",
                     pulses, frame_count_out, state_out);
        end
    endtask

    task automatic test_abort();
        for (int j = 0; j < FW; j++) begin
            drive(j, 1'b1, j, j <= 5);
            cyc();
        end
        drive(0, 1'b0, 0, 1'b0);
        checks++;
        if (cam_done_out !== 2'b01) begin
            failures++;
            $display("FAIL abort_pre: done=%b required 01", cam_done_out);
        end
        pacing_in = 1'b0;
        cyc();
        checks++;
        if (state_out !== 2'd0 || cam_done_out !== 2'b00 || new_frame_out !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: state=%0d done=%b nf=%b required 0/00/0",
                     state_out, cam_done_out, new_frame_out);
        end
        pacing_in = 1'b1;
        cyc();
        for (int j = 0; j < FW; j++) begin
            drive(0, 1'b0, j, 1'b1);
            cyc();
        end
        drive(0, 1'b0, 0, 1'b0);
        cyc();
        cyc();
        checks++;
        if (cam_done_out !== 2'b10 || new_frame_out !== 1'b0 || state_out !== 2'd1) begin
            failures++;
            $display("FAIL abort_needs_both: done=%b nf=%b state=%0d required 10/0/1",
                     cam_done_out, new_frame_out, state_out);
        end
        for (int j = 0; j < FW; j++) begin
            drive(j, 1'b1, 0, 1'b0);
            cyc();
        end
        drive(0, 1'b0, 0, 1'b0);
        // Done pulse presented on the PROCESS entry edge must be ignored.
        frame_done_in = 1'b1;
        cyc();
        frame_done_in = 1'b0;
        checks++;
        if (new_frame_out !== 1'b1 || state_out !== 2'd2) begin
            failures++;
            $display("FAIL abort_rearm_pulse: nf=%b state=%0d required 1/2", new_frame_out, state_out);
        end
        pacing_in = 1'b0;
        cyc();
        cyc();
        checks++;
        if (state_out !== 2'd2) begin
            failures++;
            $display("FAIL process_no_abort: state=%0d required 2", state_out);
        end
        test_process_done(2'd3, 2'd0);
    endtask

    task automatic test_wrap();
        pacing_in = 1'b1;
        cyc();
        for (int k = 0; k < FW; k++) begin
            drive(k, 1'b1, k, 1'b1);
            cyc();
        end
        drive(0, 1'b0, 0, 1'b0);
        cyc();
        checks++;
        if (new_frame_out !== 1'b1) begin
            failures++;
            $display("FAIL wrap_pulse: nf=%b required 1", new_frame_out);
        end
        single_shot_in = 1'b1;
        test_process_done(2'd0, 2'd0);
        single_shot_in = 1'b0;
        pacing_in = 1'b0;
        cyc();
    endtask

    task automatic test_reset_midframe();
        pacing_in = 1'b1;
        cyc();
        for (int k = 0; k < 6; k++) begin
            drive(k, 1'b1, k, 1'b1);
            cyc();
        end
        drive(6, 1'b1, 6, 1'b1);
        #2;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if ({state_out, cam_done_out, collecting_out, new_frame_out, get_output_out,
             frame_count_out, timeout_out, cam_wea_out} !== '0) begin
            failures++;
            $display("FAIL reset_midframe: state=%0d done=%b wea=%b go=%b cnt=%0d required all 0",
                     state_out, cam_done_out, cam_wea_out, get_output_out, frame_count_out);
        end
        cyc();
        rst_n_in = 1'b1;
        pacing_in = 1'b0;
        drive(0, 1'b0, 0, 1'b0);
        cyc();
    endtask

`ifdef FRAME_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        pacing_in = 1'b1;
        cyc();
        for (int k = 0; k < FW; k++) begin
            drive(k, 1'b1, 0, 1'b0);
            cyc();
        end
        drive(0, 1'b0, 0, 1'b0);
        for (int c = 0; c < 34; c++) cyc();
        checks++;
        if (timeout_out !== 1'b0 || cam_done_out !== 2'b01) begin
            failures++;
            $display("FAIL timeout_early: to=%b done=%b required 0/01", timeout_out, cam_done_out);
        end
        cyc();
        checks++;
        if (timeout_out !== 1'b1 || cam_done_out !== 2'b00 || state_out !== 2'd1) begin
            failures++;
            $display("FAIL timeout_fire: to=%b done=%b state=%0d required 1/00/1",
                     timeout_out, cam_done_out, state_out);
        end
        drive(3, 1'b1, 0, 1'b0);
        #2;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (timeout_out !== 1'b0 || state_out !== 2'd0 || cam_wea_out !== 2'b00) begin
            failures++;
            $display("FAIL timeout_reset: to=%b state=%0d wea=%b required 0/0/00",
                     timeout_out, state_out, cam_wea_out);
        end
        cyc();
        rst_n_in = 1'b1;
        pacing_in = 1'b0;
        drive(0, 1'b0, 0, 1'b0);
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_process_done(2'd1, 2'd1);
        test_late_entry();
        test_single_shot();
        test_abort();
        test_wrap();
        test_reset_midframe();
`ifdef FRAME_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
